// File: rtl/uart_rx_fsm.sv
// UART receiver control FSM: walks one frame through start/data/parity/stop,
// drives the datapath strobes and reports data_valid plus per-frame errors.
module uart_rx_fsm #(
    parameter int unsigned PRESCALE_W = 6,
    parameter int unsigned BIT_CNT_W  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  par_en,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic [BIT_CNT_W-1:0]  bit_cnt,
    input  logic [PRESCALE_W-1:0] edge_cnt,
    input  logic                  strt_glitch,
    input  logic                  par_err_in,
    input  logic                  stp_err_in,
    output logic                  enable,
    output logic                  dat_samp_en,
    output logic                  strt_chk_en,
    output logic                  deser_en,
    output logic                  par_chk_en,
    output logic                  stp_chk_en,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);
    localparam int unsigned LAST_DATA_BIT = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_par_en_q;
    logic                  r_glitch;
    logic                  r_par_err;
    logic                  r_stp_err;
    logic [PRESCALE_W-1:0] w_cp_cnt;
    logic                  w_cp;
    logic                  w_eob;
    logic                  w_frame_start;

    // Check point sits just past mid-bit where the majority sample is stable
    assign w_cp_cnt      = (prescale >> 1) + PRESCALE_W'(1);
    assign w_cp          = (edge_cnt == w_cp_cnt);
    assign w_eob         = (edge_cnt == (prescale - PRESCALE_W'(1)));
    assign w_frame_start = ((r_state == IDLE) || (r_state == DONE)) && !RX_IN;

    assign busy    = (r_state != IDLE);
    assign par_err = r_par_err;
    assign stp_err = r_stp_err;

    // State register
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Per-frame captures: cleared when a new frame starts, loaded at check points
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_par_en_q <= 1'b0;
            r_glitch   <= 1'b0;
            r_par_err  <= 1'b0;
            r_stp_err  <= 1'b0;
        end else if (w_frame_start) begin
            r_par_en_q <= par_en;
            r_glitch   <= 1'b0;
            r_par_err  <= 1'b0;
            r_stp_err  <= 1'b0;
        end else if (w_cp) begin
            case (r_state)
                START:   r_glitch  <= strt_glitch;
                PARITY:  r_par_err <= par_err_in;
                STOP:    r_stp_err <= stp_err_in;
                default: ;
            endcase
        end
    end

    // Next state and Moore-decoded strobes
    always_comb begin
        w_next      = r_state;
        enable      = 1'b0;
        dat_samp_en = 1'b0;
        strt_chk_en = 1'b0;
        deser_en    = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        data_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!RX_IN) w_next = START;
            end
            START: begin
                enable      = 1'b1;
                dat_samp_en = 1'b1;
                strt_chk_en = w_cp;
                if (w_eob) w_next = r_glitch ? IDLE : DATA;
            end
            DATA: begin
                enable      = 1'b1;
                dat_samp_en = 1'b1;
                deser_en    = w_cp;
                if (w_eob && (bit_cnt == BIT_CNT_W'(LAST_DATA_BIT))) begin
                    w_next = r_par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                enable      = 1'b1;
                dat_samp_en = 1'b1;
                par_chk_en  = w_cp;
                if (w_eob) w_next = STOP;
            end
            STOP: begin
                enable      = 1'b1;
                dat_samp_en = 1'b1;
                stp_chk_en  = w_cp;
                if (w_eob) w_next = DONE;
            end
            DONE: begin
                data_valid = ~r_par_err & ~r_stp_err;
                w_next     = RX_IN ? IDLE : START;
            end
            default: w_next = IDLE;
        endcase
    end
endmodule
